// File: rtl/nios2os_irq_pkg.sv
// Shared constants and helpers for the Nios II interrupt aggregator:
// register word addresses, source-count limit and the priority encoder.
package nios2os_irq_pkg;

    localparam int MAX_IRQ           = 16;
    localparam int HIGHEST_VALID_BIT = 15;

    localparam logic [2:0] ADDR_PENDING   = 3'd0;
    localparam logic [2:0] ADDR_ENABLE    = 3'd1;
    localparam logic [2:0] ADDR_EDGE_MODE = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE    = 3'd3;
    localparam logic [2:0] ADDR_HIGHEST   = 3'd4;
    localparam logic [2:0] ADDR_SW_SET    = 3'd5;

    // Lowest set index wins; returns 0 when nothing is set.
    function automatic logic [3:0] lowest_set_index(input logic [MAX_IRQ-1:0] bits);
        logic [3:0] idx;
        idx = '0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/nios2os_irq_sync_edge.sv
// Per-source two-flop synchroniser plus one history flop for rising-edge detection.
module nios2os_irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic irq_async,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= irq_async;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/nios2os_irq_aggregator.sv
// Avalon-MM interrupt aggregator: synchronised sources, sticky/level pending,
// enable mask, priority encoder and a single registered CPU interrupt.
module nios2os_irq_aggregator
    import nios2os_irq_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq
);

    logic [NUM_IRQ-1:0] level_bits;
    logic [NUM_IRQ-1:0] rise_bits;
    logic [NUM_IRQ-1:0] sticky;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] edge_mode;

    logic [NUM_IRQ-1:0] wr_bits;
    logic [NUM_IRQ-1:0] w1c_mask;
    logic [NUM_IRQ-1:0] sw_set_mask;
    logic [NUM_IRQ-1:0] set_mask;
    logic [NUM_IRQ-1:0] enable_next;
    logic [NUM_IRQ-1:0] edge_mode_next;
    logic [NUM_IRQ-1:0] sticky_next;
    logic [NUM_IRQ-1:0] pending_next;

    logic [MAX_IRQ-1:0] pending_wide;
    logic [MAX_IRQ-1:0] enable_wide;
    logic [MAX_IRQ-1:0] edge_mode_wide;
    logic [MAX_IRQ-1:0] active_wide;
    logic [15:0]        highest;
    logic [15:0]        read_value;

    logic wr_strobe;
    logic rd_strobe;
    logic clear_all;
    logic unused_writedata;

    genvar g;
    generate
        for (g = 0; g < NUM_IRQ; g++) begin : gen_src
            nios2os_irq_sync_edge u_sync (
                .clk       (clk),
                .reset     (reset),
                .irq_async (irq_in[g]),
                .level     (level_bits[g]),
                .rise      (rise_bits[g])
            );
        end
    endgenerate

    assign wr_strobe        = chipselect & ~write_n;
    assign rd_strobe        = chipselect & write_n;
    assign wr_bits          = writedata[NUM_IRQ-1:0];
    assign unused_writedata = ^writedata;

    // Set terms are OR-ed in after every clear so a coincident event is never lost.
    always_comb begin
        w1c_mask       = '0;
        sw_set_mask    = '0;
        clear_all      = 1'b0;
        enable_next    = enable;
        edge_mode_next = edge_mode;
        if (wr_strobe) begin
            case (address)
                ADDR_PENDING:   w1c_mask       = wr_bits;
                ADDR_ENABLE:    enable_next    = wr_bits;
                ADDR_EDGE_MODE: begin
                    edge_mode_next = wr_bits;
                    clear_all      = 1'b1;
                end
                ADDR_SW_SET:    sw_set_mask    = wr_bits;
                default:        ;
            endcase
        end
        set_mask = (rise_bits & edge_mode_next) | sw_set_mask;
        if (clear_all) begin
            sticky_next = set_mask;
        end else begin
            sticky_next = (sticky & ~w1c_mask) | set_mask;
        end
        pending_next = sticky_next | (level_bits & ~edge_mode_next);
    end

    always_comb begin
        pending_wide                  = '0;
        enable_wide                   = '0;
        edge_mode_wide                = '0;
        pending_wide[NUM_IRQ-1:0]     = pending;
        enable_wide[NUM_IRQ-1:0]      = enable;
        edge_mode_wide[NUM_IRQ-1:0]   = edge_mode;
        active_wide                   = pending_wide & enable_wide;
        highest                       = '0;
        highest[HIGHEST_VALID_BIT]    = |active_wide;
        highest[3:0]                  = lowest_set_index(active_wide);
    end

    always_comb begin
        read_value = '0;
        case (address)
            ADDR_PENDING:   read_value = pending_wide;
            ADDR_ENABLE:    read_value = enable_wide;
            ADDR_EDGE_MODE: read_value = edge_mode_wide;
            ADDR_ACTIVE:    read_value = active_wide;
            ADDR_HIGHEST:   read_value = highest;
            default:        read_value = '0;
        endcase
    end

    // irq is computed from the registered pending/enable, so it trails them by one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky    <= '0;
            pending   <= '0;
            enable    <= '0;
            edge_mode <= '0;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            sticky    <= sticky_next;
            pending   <= pending_next;
            enable    <= enable_next;
            edge_mode <= edge_mode_next;
            irq       <= |(pending & enable);
            if (rd_strobe) begin
                readdata <= read_value;
            end
        end
    end

endmodule

// File: tb/tb_nios2os_irq_aggregator.sv
// Scoreboard bench: reads push expected data, a negedge monitor pops and compares.
module tb_nios2os_irq_aggregator;
    import nios2os_irq_pkg::*;

    localparam int NUM_IRQ = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_IRQ-1:0] irq_in = '0;
    logic [2:0]         address = '0;
    logic               chipselect = 1'b0;
    logic               write_n = 1'b1;
    logic [15:0]        writedata = '0;
    logic [15:0]        readdata;
    logic               irq;
    logic               rd_valid;

    typedef struct {
        string       name;
        logic [15:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    nios2os_irq_aggregator #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // A read issued at one edge presents readdata after that edge.
    always @(posedge clk or posedge reset) begin
        if (reset) rd_valid <= 1'b0;
        else       rd_valid <= chipselect & write_n;
    end

    always @(negedge clk) begin
        if (rd_valid) begin
            exp_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_read: got=%h expected=no read outstanding", readdata);
            end else begin
                e = exp_q.pop_front();
                if (readdata !== e.value) begin
                    bad++;
                    $display("[TB] FAIL %s: got=%h expected=%h", e.name, readdata, e.value);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input bit is_write, input logic [2:0] addr,
                                  input logic [15:0] data, input string name,
                                  input logic [15:0] expected);
        exp_t e;
        chipselect = 1'b1;
        write_n    = ~is_write;
        address    = addr;
        writedata  = data;
        if (!is_write) begin
            e.name  = name;
            e.value = expected;
            exp_q.push_back(e);
        end
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [15:0] data);
        apply_stimulus(1'b1, addr, data, "write", 16'h0000);
    endtask

    task automatic bus_read(input logic [2:0] addr, input logic [15:0] expected, input string name);
        apply_stimulus(1'b0, addr, 16'h0000, name, expected);
    endtask

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        wait_cycles(3);
        reset = 1'b0;
        tick();

        $display("[TB] reset values");
        check_output("irq_after_reset", {15'h0, irq}, 16'h0000);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), 16'h0000, $sformatf("reset_read_addr%0d", a));
        end

        $display("[TB] edge source 0");
        bus_write(ADDR_ENABLE, 16'h0005);
        bus_write(ADDR_EDGE_MODE, 16'h0001);
        irq_in = 8'h01;
        wait_cycles(3);
        irq_in = 8'h00;
        check_output("edge0_irq_not_yet", {15'h0, irq}, 16'h0000);
        bus_read(ADDR_PENDING, 16'h0001, "edge0_pending");
        check_output("edge0_irq_set", {15'h0, irq}, 16'h0001);
        bus_read(ADDR_HIGHEST, 16'h8000, "edge0_highest");
        bus_write(ADDR_PENDING, 16'h0001);
        check_output("edge0_irq_at_w1c_edge", {15'h0, irq}, 16'h0001);
        tick();
        check_output("edge0_irq_cleared", {15'h0, irq}, 16'h0000);

        $display("[TB] level source 2");
        irq_in = 8'h04;
        wait_cycles(4);
        check_output("level2_irq_set", {15'h0, irq}, 16'h0001);
        bus_write(ADDR_PENDING, 16'h0004);
        bus_read(ADDR_PENDING, 16'h0004, "level2_pending_after_w1c");
        check_output("level2_irq_held", {15'h0, irq}, 16'h0001);
        irq_in = 8'h00;
        wait_cycles(3);
        check_output("level2_irq_before_drop", {15'h0, irq}, 16'h0001);
        bus_read(ADDR_PENDING, 16'h0000, "level2_pending_dropped");
        check_output("level2_irq_dropped", {15'h0, irq}, 16'h0000);

        $display("[TB] priority and masking");
        irq_in = 8'h8A;
        wait_cycles(4);
        bus_write(ADDR_ENABLE, 16'h0088);
        bus_read(ADDR_ACTIVE, 16'h0088, "prio_active");
        bus_read(ADDR_HIGHEST, 16'h8003, "prio_highest");
        check_output("prio_irq_set", {15'h0, irq}, 16'h0001);
        bus_write(ADDR_ENABLE, 16'h0000);
        check_output("prio_irq_at_mask_edge", {15'h0, irq}, 16'h0001);
        tick();
        check_output("prio_irq_masked", {15'h0, irq}, 16'h0000);
        bus_read(ADDR_PENDING, 16'h008A, "prio_pending_kept");
        irq_in = 8'h00;
        wait_cycles(4);

        $display("[TB] edge and w1c collide");
        bus_write(ADDR_EDGE_MODE, 16'h0011);
        bus_write(ADDR_ENABLE, 16'h0010);
        irq_in = 8'h10;
        wait_cycles(2);
        bus_write(ADDR_PENDING, 16'h0010);
        bus_read(ADDR_PENDING, 16'h0010, "collide_set_wins");
        bus_write(ADDR_PENDING, 16'h0010);
        bus_read(ADDR_PENDING, 16'h0000, "held_edge_no_rearm");
        check_output("held_edge_irq_low", {15'h0, irq}, 16'h0000);
        irq_in = 8'h00;
        wait_cycles(3);

        $display("[TB] software set and reset");
        bus_write(ADDR_ENABLE, 16'h0040);
        bus_write(ADDR_SW_SET, 16'h0040);
        check_output("swset_irq_at_write_edge", {15'h0, irq}, 16'h0000);
        tick();
        check_output("swset_irq_set", {15'h0, irq}, 16'h0001);
        bus_read(ADDR_SW_SET, 16'h0000, "swset_reads_zero");
        bus_read(ADDR_PENDING, 16'h0040, "swset_pending");
        tick();
        reset = 1'b1;
        #1;
        check_output("midreset_irq", {15'h0, irq}, 16'h0000);
        check_output("midreset_readdata", readdata, 16'h0000);
        wait_cycles(2);
        reset = 1'b0;
        tick();
        bus_read(ADDR_PENDING, 16'h0000, "postreset_pending");
        bus_read(ADDR_ENABLE, 16'h0000, "postreset_enable");
        bus_read(ADDR_EDGE_MODE, 16'h0000, "postreset_edge_mode");
        check_output("postreset_irq", {15'h0, irq}, 16'h0000);

        wait_cycles(3);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain: got=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
